bus_initiator: RTL and testbench

- 68000-style asynchronous bus-cycle initiator. It converts a simple single-beat request/acknowledge interface into AS/UDS/LDS/WR strobe sequences, then waits for DTACK or BERR from the bus responder (BusControl decode path).
- Used for monitor-driven DMA/bus mastering while the CPU is held off the bus.
- Runs on MCLK. Performs one transfer at a time.

---
 rtl/pixy_bus_pkg.sv | 26 ++
 rtl/bus_wait_timer.sv | 36 +++
 rtl/bus_initiator.sv | 166 ++++++++++++++++
 tb/tb_bus_initiator.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pixy_bus_pkg.sv
// Shared types for the 68000-style bus initiator: FSM states, byte-lane codes, default widths.
package pixy_bus_pkg;

  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DATA_W = 16;

  localparam logic [1:0] BE_NONE  = 2'b00;
  localparam logic [1:0] BE_UPPER = 2'b10;
  localparam logic [1:0] BE_LOWER = 2'b01;
  localparam logic [1:0] BE_WORD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    ASSERT  = 3'd2,
    WAIT    = 3'd3,
    LATCH   = 3'd4,
    RELEASE = 3'd5
  } bus_state_t;

  // Data strobes lag AS by one cycle on writes so write data is set up first.
  function automatic logic lanes_active(input bus_state_t st, input logic wr);
    return (st == WAIT) || (st == LATCH) || ((st == ASSERT) && !wr);
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// WAIT-state watchdog: clear restarts the count, enable counts one WAIT cycle; expired flags the last allowed cycle.
// Zero latency on expired_o (combinational from count and enable); no backpressure.
module bus_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMR_W          = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // The count is the number of WAIT cycles already spent, so the Nth cycle sees N-1.
  assign expired_o = enable_i && (cnt_q == TMR_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_initiator.sv
// Single-beat request/ack to 68000 AS/UDS/LDS/WR bus cycle; ACK 5 cycles after acceptance plus extra WAIT cycles; one transfer at a time, REQ ignored while busy.
// Optional BUS_TIMEOUT_EN adds a WAIT-state timeout reported through ERR_OUT/TIMEOUT_OUT.
module bus_initiator
  import pixy_bus_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMR_W          = 8
) (
  input  logic              MCLK_IN,
  input  logic              RESET_n_IN,
  input  logic              REQ_IN,
  input  logic              REQ_WR_IN,
  input  logic [1:0]        REQ_BYTE_EN_IN,
  input  logic [ADDR_W-1:0] REQ_ADDR_IN,
  input  logic [DATA_W-1:0] REQ_WDATA_IN,
  output logic              READY_OUT,
  output logic              ACK_OUT,
  output logic              ERR_OUT,
  output logic              TIMEOUT_OUT,
  output logic [DATA_W-1:0] RDATA_OUT,
  output logic              AS_OUT,
  output logic              UDS_OUT,
  output logic              LDS_OUT,
  output logic              WR_OUT,
  output logic [ADDR_W-1:0] ADDR_OUT,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DATA_OE_OUT,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              DTACK_IN,
  input  logic              BERR_IN
);

  if (TIMEOUT_CYCLES >= 2 ** TMR_W) begin : g_bad_tmr_w
    $error("bus_initiator: TIMEOUT_CYCLES does not fit in TMR_W bits");
  end

  bus_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic [1:0]        be_q;
  logic              nobus_q, nobus_d;
  logic              err_q, err_d;
  logic              to_q, to_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              accept;
  logic              req_nobus;
  logic              tmr_expired;
  logic              bus_phase;
  logic              lanes;

`ifdef BUS_TIMEOUT_EN
  bus_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_wait_timer (
    .clk_i    (MCLK_IN),
    .rst_ni   (RESET_n_IN),
    .clear_i  (state_q == ASSERT),
    .enable_i (state_q == WAIT),
    .expired_o(tmr_expired)
  );
`else
  assign tmr_expired = 1'b0;
`endif

  assign accept    = REQ_IN && (state_q == IDLE);
  assign req_nobus = (REQ_BYTE_EN_IN & BE_WORD) == BE_NONE;

  always_comb begin
    state_d = state_q;
    nobus_d = nobus_q;
    err_d   = err_q;
    to_d    = to_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          err_d   = req_nobus;
          to_d    = 1'b0;
          nobus_d = req_nobus;
          state_d = req_nobus ? RELEASE : ADDR;
        end
      end
      ADDR:   state_d = ASSERT;
      ASSERT: state_d = WAIT;
      WAIT: begin
        // BERR outranks DTACK, and any responder answer outranks the timeout.
        if (BERR_IN) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end else if (DTACK_IN) begin
          state_d = LATCH;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = RELEASE;
        end
      end
      LATCH: begin
        if (!wr_q) begin
          rdata_d = DATA_IN;
        end
        state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MCLK_IN or negedge RESET_n_IN) begin
    if (!RESET_n_IN) begin
      state_q <= IDLE;
      nobus_q <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      nobus_q <= nobus_d;
      err_q   <= err_d;
      to_q    <= to_d;
      rdata_q <= rdata_d;
    end
  end

  // Transfer attributes only change for real bus cycles, so ADDR_OUT keeps the last bus address.
  always_ff @(posedge MCLK_IN or negedge RESET_n_IN) begin
    if (!RESET_n_IN) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      be_q    <= BE_NONE;
    end else if (accept && !req_nobus) begin
      addr_q  <= REQ_ADDR_IN;
      wdata_q <= REQ_WDATA_IN;
      wr_q    <= REQ_WR_IN;
      be_q    <= REQ_BYTE_EN_IN;
    end
  end

  assign bus_phase = (state_q != IDLE) && !nobus_q;
  assign lanes     = lanes_active(state_q, wr_q);

  always_comb begin
    READY_OUT   = (state_q == IDLE);
    ACK_OUT     = (state_q == RELEASE);
    ERR_OUT     = (state_q == RELEASE) && err_q;
`ifdef BUS_TIMEOUT_EN
    TIMEOUT_OUT = (state_q == RELEASE) && to_q;
`else
    TIMEOUT_OUT = 1'b0;
`endif
    AS_OUT      = (state_q == ASSERT) || (state_q == WAIT) || (state_q == LATCH);
    UDS_OUT     = lanes && |(be_q & BE_UPPER);
    LDS_OUT     = lanes && |(be_q & BE_LOWER);
    WR_OUT      = bus_phase && wr_q;
    DATA_OE_OUT = bus_phase && wr_q;
    ADDR_OUT    = addr_q & ~ADDR_W'(1);
    DATA_OUT    = wdata_q;
    RDATA_OUT   = rdata_q;
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: stimulus pushes expected ACK results into a scoreboard drained by a monitor.
module tb_bus_initiator;

  localparam int AW = 24;
  localparam int DW = 16;
`ifdef BUS_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 255;
`endif

  logic          MCLK_IN = 1'b0;
  logic          RESET_n_IN;
  logic          REQ_IN, REQ_WR_IN;
  logic [1:0]    REQ_BYTE_EN_IN;
  logic [AW-1:0] REQ_ADDR_IN;
  logic [DW-1:0] REQ_WDATA_IN;
  logic          READY_OUT, ACK_OUT, ERR_OUT, TIMEOUT_OUT;
  logic [DW-1:0] RDATA_OUT;
  logic          AS_OUT, UDS_OUT, LDS_OUT, WR_OUT;
  logic [AW-1:0] ADDR_OUT;
  logic [DW-1:0] DATA_OUT;
  logic          DATA_OE_OUT;
  logic [DW-1:0] DATA_IN;
  logic          DTACK_IN = 1'b0;
  logic          BERR_IN = 1'b0;

  bus_initiator #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO_CYC), .TMR_W(8)
  ) dut (
    .MCLK_IN(MCLK_IN), .RESET_n_IN(RESET_n_IN), .REQ_IN(REQ_IN), .REQ_WR_IN(REQ_WR_IN),
    .REQ_BYTE_EN_IN(REQ_BYTE_EN_IN), .REQ_ADDR_IN(REQ_ADDR_IN), .REQ_WDATA_IN(REQ_WDATA_IN),
    .READY_OUT(READY_OUT), .ACK_OUT(ACK_OUT), .ERR_OUT(ERR_OUT), .TIMEOUT_OUT(TIMEOUT_OUT),
    .RDATA_OUT(RDATA_OUT), .AS_OUT(AS_OUT), .UDS_OUT(UDS_OUT), .LDS_OUT(LDS_OUT),
    .WR_OUT(WR_OUT), .ADDR_OUT(ADDR_OUT), .DATA_OUT(DATA_OUT), .DATA_OE_OUT(DATA_OE_OUT),
    .DATA_IN(DATA_IN), .DTACK_IN(DTACK_IN), .BERR_IN(BERR_IN)
  );

  always #5 MCLK_IN = ~MCLK_IN;

  int cyc = 0;
  always @(posedge MCLK_IN) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int n_ack  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4:0] strb();
    return {AS_OUT, UDS_OUT, LDS_OUT, WR_OUT, DATA_OE_OUT};
  endfunction

  // Responder: answers once AS has been seen for 2+extra negedges (extra = WAIT cycles without DTACK).
  bit dt_en = 1'b0;
  bit be_en = 1'b0;
  int extra = 0;
  int as_cnt = 0;
  logic [DW-1:0] resp_data = '0;
  always @(negedge MCLK_IN) begin
    if (AS_OUT) as_cnt++;
    else as_cnt = 0;
    DTACK_IN = dt_en && AS_OUT && (as_cnt >= 2 + extra);
    BERR_IN  = be_en && AS_OUT && (as_cnt >= 2 + extra);
    DATA_IN  = resp_data;
  end

  typedef struct {
    int            ack_cyc;
    bit            err;
    bit            to;
    logic [DW-1:0] rd;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic prev_as = 1'b0;
  logic prev_wr = 1'b0;

  always @(negedge MCLK_IN) begin
    if (RESET_n_IN === 1'b1) begin
      chk("invariants",
          {31'd0, (!ACK_OUT && (ERR_OUT || TIMEOUT_OUT)) || (DATA_OE_OUT && !WR_OUT) ||
                  (AS_OUT && prev_as && (WR_OUT != prev_wr)) ||
                  (ACK_OUT && (AS_OUT || UDS_OUT || LDS_OUT))}, 32'd0);
      if (ACK_OUT) begin
        n_ack++;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ack: got ACK at cycle %0d, required none", cyc);
        end else begin
          e = sb.pop_front();
          chk("ack_cycle", cyc, e.ack_cyc);
          chk("ack_err", {31'd0, ERR_OUT}, {31'd0, e.err});
          chk("ack_timeout", {31'd0, TIMEOUT_OUT}, {31'd0, e.to});
          chk("ack_rdata", {16'd0, RDATA_OUT}, {16'd0, e.rd});
        end
      end
    end
    prev_as = AS_OUT;
    prev_wr = WR_OUT;
  end

  // Drives a one-cycle request from the current negedge; returns at the following negedge.
  task automatic issue(input bit wr, input logic [1:0] be, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input bit want_ack, input int lat,
                       input bit err, input bit to, input logic [DW-1:0] rd, output int c);
    exp_t x;
    c = cyc;
    if (want_ack) begin
      x.ack_cyc = c + lat;
      x.err = err;
      x.to = to;
      x.rd = rd;
      sb.push_back(x);
    end
    REQ_IN = 1'b1;
    REQ_WR_IN = wr;
    REQ_BYTE_EN_IN = be;
    REQ_ADDR_IN = a;
    REQ_WDATA_IN = wd;
    @(negedge MCLK_IN);
    REQ_IN = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    int ack0;
    logic [4:0] rd_tab [1:7];
    logic [4:0] wr_tab [1:6];
    rd_tab = '{5'b00000, 5'b11100, 5'b11100, 5'b11100, 5'b11100, 5'b11100, 5'b00000};
    wr_tab = '{5'b00011, 5'b10011, 5'b11011, 5'b11011, 5'b00011, 5'b00000};

    RESET_n_IN = 1'b0;
    REQ_IN = 1'b0; REQ_WR_IN = 1'b0; REQ_BYTE_EN_IN = 2'b00;
    REQ_ADDR_IN = '0; REQ_WDATA_IN = '0;
    repeat (3) @(negedge MCLK_IN);
    chk("rst_ready", {31'd0, READY_OUT}, 32'd1);
    chk("rst_ack_err_to", {29'd0, ACK_OUT, ERR_OUT, TIMEOUT_OUT}, 32'd0);
    chk("rst_strobes", {27'd0, strb()}, 32'd0);
    chk("rst_rdata", {16'd0, RDATA_OUT}, 32'd0);
    chk("rst_addr", {8'd0, ADDR_OUT}, 32'd0);
    RESET_n_IN = 1'b1;
    @(negedge MCLK_IN);

    // Word read, DTACK after two idle WAIT cycles.
    resp_data = 16'hBEEF; dt_en = 1; extra = 2;
    issue(1'b0, 2'b11, 24'h000100, 16'h0, 1'b1, 7, 1'b0, 1'b0, 16'hBEEF, c);
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("rd_strobes_k%0d", k), {27'd0, strb()}, {27'd0, rd_tab[k]});
      if (k == 2) chk("rd_addr", {8'd0, ADDR_OUT}, 32'h000100);
      @(negedge MCLK_IN);
    end
    chk("rd_ready_after", {31'd0, READY_OUT}, 32'd1);

    // Upper-byte write, immediate DTACK.
    extra = 0; resp_data = 16'h0000;
    issue(1'b1, 2'b10, 24'h200001, 16'h5A00, 1'b1, 5, 1'b0, 1'b0, 16'hBEEF, c);
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("wr_strobes_k%0d", k), {27'd0, strb()}, {27'd0, wr_tab[k]});
      if (k == 1) begin
        chk("wr_addr", {8'd0, ADDR_OUT}, 32'h200000);
        chk("wr_data", {16'd0, DATA_OUT}, 32'h5A00);
      end
      @(negedge MCLK_IN);
    end

    // DTACK and BERR together: BERR wins, RDATA untouched.
    be_en = 1; resp_data = 16'h1234;
    issue(1'b0, 2'b11, 24'h000300, 16'h0, 1'b1, 4, 1'b1, 1'b0, 16'hBEEF, c);
    repeat (6) @(negedge MCLK_IN);
    be_en = 0;

    // Empty byte enables: no bus cycle, ACK+ERR next cycle, bus address held.
    issue(1'b0, 2'b00, 24'h000400, 16'h0, 1'b1, 1, 1'b1, 1'b0, 16'hBEEF, c);
    chk("nobe_as_k1", {31'd0, AS_OUT}, 32'd0);
    chk("nobe_addr_held", {8'd0, ADDR_OUT}, 32'h000300);
    @(negedge MCLK_IN);
    chk("nobe_as_k2", {31'd0, AS_OUT}, 32'd0);
    chk("nobe_ready_k2", {31'd0, READY_OUT}, 32'd1);

    // A second request while busy must be dropped.
    ack0 = n_ack;
    issue(1'b1, 2'b11, 24'h000500, 16'h1111, 1'b1, 5, 1'b0, 1'b0, 16'hBEEF, c);
    @(negedge MCLK_IN);
    REQ_IN = 1'b1; REQ_WR_IN = 1'b0; REQ_ADDR_IN = 24'h000600; REQ_BYTE_EN_IN = 2'b11;
    repeat (2) @(negedge MCLK_IN);
    REQ_IN = 1'b0;
    repeat (6) @(negedge MCLK_IN);
    chk("busy_one_ack", n_ack - ack0, 32'd1);
    chk("busy_addr", {8'd0, ADDR_OUT}, 32'h000500);

`ifdef BUS_TIMEOUT_EN
    // No responder: timeout after four WAIT cycles.
    dt_en = 0;
    issue(1'b0, 2'b01, 24'h000700, 16'h0, 1'b1, 7, 1'b1, 1'b1, 16'hBEEF, c);
    repeat (9) @(negedge MCLK_IN);
`endif

    // Hung write, then reset in WAIT.
    dt_en = 0;
    issue(1'b1, 2'b11, 24'h000800, 16'hCAFE, 1'b0, 0, 1'b0, 1'b0, 16'h0, c);
`ifdef BUS_TIMEOUT_EN
    repeat (2) @(negedge MCLK_IN);
`else
    repeat (1000) @(negedge MCLK_IN);
`endif
    chk("hang_as_still_high", {31'd0, AS_OUT}, 32'd1);
    chk("hang_not_ready", {31'd0, READY_OUT}, 32'd0);
    chk("hang_oe_high", {31'd0, DATA_OE_OUT}, 32'd1);
    #2 RESET_n_IN = 1'b0;
    #1;
    chk("rstmid_strobes", {27'd0, strb()}, 32'd0);
    chk("rstmid_ack", {31'd0, ACK_OUT}, 32'd0);
    repeat (2) @(negedge MCLK_IN);
    RESET_n_IN = 1'b1;
    @(negedge MCLK_IN);
    chk("rstmid_ready_after", {31'd0, READY_OUT}, 32'd1);
    chk("rstmid_rdata_cleared", {16'd0, RDATA_OUT}, 32'd0);
    repeat (5) @(negedge MCLK_IN);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
